// File: rtl/booth_divider.sv
// Sequential radix-2 restoring divider: 2N-bit dividend / N-bit divisor, start/busy/done handshake.
// Define DIV_SIGNED_EN for two's-complement operands; the default build divides unsigned values.
module booth_divider #(
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             reset_to_zero,
  input  logic             start,
  input  logic [2*N-1:0]   dividend,
  input  logic [N-1:0]     divisor,
  output logic [2*N-1:0]   quotient,
  output logic [N-1:0]     remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             ovf
);

  localparam int CW = $clog2(2*N);
  localparam logic [CW-1:0] LAST = CW'(2*N-1);

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [2*N-1:0]   dd_q, dd_d;
  logic [N-1:0]     dv_q, dv_d;
  logic [2*N-1:0]   acc_q, acc_d;
  logic [N-1:0]     rem_q, rem_d;
  logic [N-1:0]     mag_dv_q, mag_dv_d;
  logic             dbz_q, dbz_d;
  logic [2*N-1:0]   quotient_q, quotient_d;
  logic [N-1:0]     remainder_q, remainder_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_by_zero_q, div_by_zero_d;
  logic [N:0]       shifted;
`ifdef DIV_SIGNED_EN
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             ovf_q, ovf_d;
`endif

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    dd_d          = dd_q;
    dv_d          = dv_q;
    acc_d         = acc_q;
    rem_d         = rem_q;
    mag_dv_d      = mag_dv_q;
    dbz_d         = dbz_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    div_by_zero_d = div_by_zero_q;
    shifted       = {rem_q, acc_q[2*N-1]};
`ifdef DIV_SIGNED_EN
    neg_quo_d     = neg_quo_q;
    neg_rem_d     = neg_rem_q;
    ovf_d         = ovf_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          dd_d    = dividend;
          dv_d    = divisor;
          busy_d  = 1'b1;
          state_d = PREP;
        end
      end
      PREP: begin
        rem_d   = '0;
        count_d = '0;
        dbz_d   = (dv_q == '0);
`ifdef DIV_SIGNED_EN
        neg_quo_d = dd_q[2*N-1] ^ dv_q[N-1];
        neg_rem_d = dd_q[2*N-1];
        acc_d     = dd_q[2*N-1] ? -dd_q : dd_q;
        mag_dv_d  = dv_q[N-1] ? -dv_q : dv_q;
`else
        acc_d     = dd_q;
        mag_dv_d  = dv_q;
`endif
        state_d = ITER;
      end
      ITER: begin
        // acc shifts dividend bits out at the top while quotient bits enter at the bottom
        if (shifted >= {1'b0, mag_dv_q}) begin
          rem_d = shifted[N-1:0] - mag_dv_q;
          acc_d = {acc_q[2*N-2:0], 1'b1};
        end else begin
          rem_d = shifted[N-1:0];
          acc_d = {acc_q[2*N-2:0], 1'b0};
        end
        count_d = count_q + CW'(1);
        if (count_q == LAST) state_d = FIX;
      end
      FIX: begin
        busy_d        = 1'b0;
        done_d        = 1'b1;
        div_by_zero_d = dbz_q;
        state_d       = IDLE;
        if (dbz_q) begin
          quotient_d  = '1;
          remainder_d = dd_q[N-1:0];
`ifdef DIV_SIGNED_EN
          ovf_d       = 1'b0;
`endif
        end else begin
`ifdef DIV_SIGNED_EN
          quotient_d  = neg_quo_q ? -acc_q : acc_q;
          remainder_d = neg_rem_q ? -rem_q : rem_q;
          ovf_d       = !neg_quo_q && (acc_q == {1'b1, {(2*N-1){1'b0}}});
`else
          quotient_d  = acc_q;
          remainder_d = rem_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_to_zero) begin
    if (reset_to_zero) begin
      state_q       <= IDLE;
      count_q       <= '0;
      dd_q          <= '0;
      dv_q          <= '0;
      acc_q         <= '0;
      rem_q         <= '0;
      mag_dv_q      <= '0;
      dbz_q         <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      ovf_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      dd_q          <= dd_d;
      dv_q          <= dv_d;
      acc_q         <= acc_d;
      rem_q         <= rem_d;
      mag_dv_q      <= mag_dv_d;
      dbz_q         <= dbz_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      div_by_zero_q <= div_by_zero_d;
`ifdef DIV_SIGNED_EN
      neg_quo_q     <= neg_quo_d;
      neg_rem_q     <= neg_rem_d;
      ovf_q         <= ovf_d;
`endif
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = div_by_zero_q;
`ifdef DIV_SIGNED_EN
  assign ovf         = ovf_q;
`else
  assign ovf         = 1'b0;
`endif

endmodule

// File: tb/tb_booth_divider.sv
// Directed self-checking bench for booth_divider (N=4); vectors follow DIV_SIGNED_EN when it is defined.
module tb_booth_divider;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_to_zero;
  logic           start;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic [2*N-1:0] quotient;
  logic [N-1:0]   remainder;
  logic           busy;
  logic           done;
  logic           div_by_zero;
  logic           ovf;

  int assertCount = 0;
  int failCount   = 0;

  booth_divider #(.N(N)) dut (
    .clk          (clk),
    .reset_to_zero(reset_to_zero),
    .start        (start),
    .dividend     (dividend),
    .divisor      (divisor),
    .quotient     (quotient),
    .remainder    (remainder),
    .busy         (busy),
    .done         (done),
    .div_by_zero  (div_by_zero),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Launches one division and waits (bounded) for done; optionally pulses start mid-flight.
  task automatic applyStimulus(input string tag, input logic [7:0] dd, input logic [3:0] dv, input bit glitch);
    int latency;
    bit busyOk;
    latency  = 0;
    busyOk   = 1'b1;
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (glitch && i == 3) begin
        dividend = ~dd;
        divisor  = dv + 4'd1;
        start    = 1'b1;
      end
      if (glitch && i == 4) start = 1'b0;
      if (done) begin
        latency = i;
        break;
      end
      if (!busy) busyOk = 1'b0;
    end
    checkOutput({tag, " latency"}, 16'(latency), 16'd10);
    checkOutput({tag, " busy_in_flight"}, 16'(busyOk), 16'd1);
    checkOutput({tag, " busy_at_done"}, 16'(busy), 16'd0);
  endtask

  task automatic checkDivision(input string tag, input logic [7:0] dd, input logic [3:0] dv,
                               input logic [7:0] expQ, input logic [3:0] expR,
                               input logic expDbz, input logic expOvf, input bit glitch);
    applyStimulus(tag, dd, dv, glitch);
    checkOutput({tag, " quotient"}, 16'(quotient), 16'(expQ));
    checkOutput({tag, " remainder"}, 16'(remainder), 16'(expR));
    checkOutput({tag, " div_by_zero"}, 16'(div_by_zero), 16'(expDbz));
    checkOutput({tag, " ovf"}, 16'(ovf), 16'(expOvf));
    @(posedge clk);
    #1;
    checkOutput({tag, " done_pulse"}, 16'(done), 16'd0);
    checkOutput({tag, " quotient_hold"}, 16'(quotient), 16'(expQ));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " quotient"}, 16'(quotient), 16'd0);
    checkOutput({tag, " remainder"}, 16'(remainder), 16'd0);
    checkOutput({tag, " busy"}, 16'(busy), 16'd0);
    checkOutput({tag, " done"}, 16'(done), 16'd0);
    checkOutput({tag, " div_by_zero"}, 16'(div_by_zero), 16'd0);
    checkOutput({tag, " ovf"}, 16'(ovf), 16'd0);
  endtask

  initial begin
    bit sawDone;
    reset_to_zero = 1'b1;
    start         = 1'b0;
    dividend      = '0;
    divisor       = '0;
    #12;
    checkAllZero("reset");
    @(negedge clk);
    reset_to_zero = 1'b0;
    @(posedge clk);
    #1;

`ifdef DIV_SIGNED_EN
    checkDivision("s_100_7",   8'h64, 4'h7, 8'h0E, 4'h2, 1'b0, 1'b0, 1'b0);
    checkDivision("s_m100_7",  8'h9C, 4'h7, 8'hF2, 4'hE, 1'b0, 1'b0, 1'b0);
    checkDivision("s_100_m7",  8'h64, 4'h9, 8'hF2, 4'h2, 1'b0, 1'b0, 1'b0);
    checkDivision("s_ovf",     8'h80, 4'hF, 8'h80, 4'h0, 1'b0, 1'b1, 1'b0);
    checkDivision("s_m128_1",  8'h80, 4'h1, 8'h80, 4'h0, 1'b0, 1'b0, 1'b0);
    checkDivision("s_127_m8",  8'h7F, 4'h8, 8'hF1, 4'h7, 1'b0, 1'b0, 1'b0);
`else
    checkDivision("u_200_7",   8'hC8, 4'h7, 8'h1C, 4'h4, 1'b0, 1'b0, 1'b0);
    checkDivision("u_255_15",  8'hFF, 4'hF, 8'h11, 4'h0, 1'b0, 1'b0, 1'b0);
    checkDivision("u_255_1",   8'hFF, 4'h1, 8'hFF, 4'h0, 1'b0, 1'b0, 1'b0);
    checkDivision("u_7_9",     8'h07, 4'h9, 8'h00, 4'h7, 1'b0, 1'b0, 1'b0);
    checkDivision("u_100_7",   8'h64, 4'h7, 8'h0E, 4'h2, 1'b0, 1'b0, 1'b0);
`endif

    checkDivision("dbz_50_0",  8'h32, 4'h0, 8'hFF, 4'h2, 1'b1, 1'b0, 1'b0);
    checkDivision("after_dbz", 8'h09, 4'h3, 8'h03, 4'h0, 1'b0, 1'b0, 1'b0);
    checkDivision("start_busy", 8'h64, 4'h7, 8'h0E, 4'h2, 1'b0, 1'b0, 1'b1);
    checkDivision("dbz_again", 8'h32, 4'h0, 8'hFF, 4'h2, 1'b1, 1'b0, 1'b0);

    dividend = 8'h64;
    divisor  = 4'h7;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset_to_zero = 1'b1;
    #1;
    checkAllZero("mid_reset");
    @(negedge clk);
    reset_to_zero = 1'b0;
    sawDone = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (done) sawDone = 1'b1;
    end
    checkOutput("no_done_after_reset", 16'(sawDone), 16'd0);
    checkDivision("fresh_9_3", 8'h09, 4'h3, 8'h03, 4'h0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/booth_divider.md
# booth_divider

Sequential divider, companion to the team's 4x4 Booth multiplier: it takes a 2N-bit product-width dividend and an N-bit divisor and returns a 2N-bit quotient and an N-bit remainder. It uses a radix-2 restoring iteration on operand magnitudes, followed by a sign fix-up. A start/busy/done handshake lets the block sit in the same datapath slot as the multiplier; one division runs at a time.

## Interface
- `N`, default 4: divisor/remainder width. Dividend and quotient are 2N bits wide.
- `clk`, in, 1: rising-edge clock.
- `reset_to_zero`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: request a division. Sampled only in IDLE.
- `dividend`, in, 2N: dividend. Two's complement when signed.
- `divisor`, in, N: divisor. Two's complement when signed.
- `quotient`, out, 2N: registered result.
- `remainder`, out, N: registered result.
- `busy`, out, 1: high while a division is in flight.
- `done`, out, 1: one-cycle pulse when new results are valid.
- `div_by_zero`, out, 1: status of the last completed division.
- `ovf`, out, 1: status of the last completed division. Quotient not representable.

## Operation
- **States.**
  - IDLE: on `start`=1 go to PREP. Otherwise stay.
  - PREP: always go to ITER.
  - ITER: stay while `count` < 2N-1. At `count` = 2N-1 go to FIX.
  - FIX: always go to IDLE.
- **IDLE.**
  - When `start` is accepted, `dividend` and `divisor` are latched into internal registers.
  - Input changes after acceptance have no effect.
- **PREP.**
  - Compute `|dividend|` (2N bits, unsigned) and `|divisor|` (N bits, unsigned).
  - Record `sign_q` = dividend sign XOR divisor sign, and `sign_r` = dividend sign.
  - Clear the partial remainder (N+1 bits) and set `count`=0.
  - Set `dbz` = (divisor == 0).
- **ITER** (one quotient bit per cycle, MSB first):
  - Shift the partial remainder left by 1 and bring in the next dividend magnitude bit.
  - Trial-subtract `|divisor|`. If the result is non-negative, keep it and set the quotient bit to 1. Otherwise restore and set the quotient bit to 0.
- **FIX:**
  - `quotient` = `sign_q` ? −q : q, truncated to 2N bits. `remainder` = `sign_r` ? −r : r, truncated to N bits.
  - Rounding is toward zero. A nonzero remainder carries the dividend's sign.
  - `ovf`=1 only when `sign_q`=0 and q = 2^(2N−1). This is the case −2^(2N−1) / −1. The quotient is then 0x80 for N=4.
  - Divide by zero: `quotient` = all ones, `remainder` = `dividend[N-1:0]`, `div_by_zero`=1, `ovf`=0. The ITER result is discarded, and the latency is unchanged.
  - `done`=1 for exactly this cycle.
- **Hold behaviour.**
  - `quotient`, `remainder`, `div_by_zero` and `ovf` hold until the next FIX.
  - `start` while `busy` is ignored. It is not queued.
  - `start` during the `done` cycle is accepted, since the state is IDLE.

## Timing
- **Reset values.** `reset_to_zero` forces all outputs to 0: `quotient`, `remainder`, `busy`, `done`, `div_by_zero`, `ovf`. State goes to IDLE and `count` to 0.
- **Reset mid-operation.** Asserting reset in any state aborts the division immediately. No `done` is produced.
- **Latency.**
  - `start` is sampled at edge k.
  - `busy` is high from after edge k until the edge that leaves FIX.
  - Results and `done` are valid after edge k+2N+2. That is 10 edges for N=4.
- **Throughput.** One division per 2N+3 cycles when `start` is held high continuously.
- **busy/done relationship.** `busy` is asserted in PREP, ITER and FIX. It is low in the cycle where `done`=1.

## Configuration
- `DIV_SIGNED_EN` defined:
  - Operands and results are two's complement.
  - Uses the PREP magnitude/sign logic and the FIX negation.
  - `ovf` is active as described above.
- `DIV_SIGNED_EN` undefined:
  - Operands are unsigned, PREP passes them through unchanged, and FIX applies no negation.
  - `ovf` is tied to 0.
  - Divide-by-zero behaviour is unchanged.

## Test plan
- **Signed, positive.** Signed build, N=4, `dividend`=100 (0x64), `divisor`=7: after 10 edges, `quotient`=14 (0x0E), `remainder`=2, `done` pulses for 1 cycle, both flags 0.
- **Signed, mixed signs.**
  - −100 / 7: `quotient`=−14 (0xF2), `remainder`=−2 (0xE).
  - 100 / −7: `quotient`=0xF2, `remainder`=2.
- **Overflow.** −128 / −1: `quotient`=0x80, `remainder`=0, `ovf`=1.
- **Divide by zero.** 50 / 0: `quotient`=0xFF, `remainder`=0x2, `div_by_zero`=1, latency still 10 edges. The next division, 9 / 3, clears the flag and gives `quotient`=3.
- **Handshake and reset.**
  - Pulse `start` again while `busy`: it is ignored, and the results reflect the first operands.
  - Assert `reset_to_zero` at edge k+5: all outputs are 0, no `done` follows, and a fresh `start` then completes normally.
- **Unsigned build** (`DIV_SIGNED_EN` undefined): 200 / 7 gives `quotient`=28 (0x1C), `remainder`=4, `ovf`=0. 255 / 15 gives `quotient`=17, `remainder`=0.
